sim_uart_rx_monitor: RTL and testbench
======================================

Name: sim_uart_rx_monitor

Overview:
Parametrised multi-channel UART receive monitor for the VeeRwolf simulation harness. It decodes one or more serial TX lines driven by the SoC (for example o_uart_tx) into bytes. Decoded bytes go into per-channel FIFOs and are presented on a valid/ready stream, so benches and Verilator wrappers can check console output cycle-accurately. Frame-error and overflow detection are included.

Parameters:
CHANNELS, 1, number of independent serial lines monitored
CLK_FREQ_HZ, 12_500_000, clk frequency in Hz
BAUD, 115200, line rate; DIV = CLK_FREQ_HZ/BAUD (integer truncation), DIV >= 4 required (elaboration error otherwise)
FIFO_DEPTH, 16, bytes buffered per channel; power of two, >= 2

Ports:
clk  input  1  system clock, single clock domain
rst  input  1  synchronous, active-high reset
i_rx  input  CHANNELS  serial lines, idle high, asynchronous to clk
i_clr  input  1  one-cycle pulse; clears sticky error flags
o_data  output  8*CHANNELS  head-of-FIFO byte; channel n at bits [8n+7:8n]
o_valid  output  CHANNELS  FIFO n non-empty
i_ready  input  CHANNELS  consumer pops channel n when o_valid[n] && i_ready[n]
o_frame_err  output  CHANNELS  sticky: a byte with stop bit 0 was seen
o_overflow  output  CHANNELS  sticky: a byte was dropped because the FIFO was full

Behaviour:
- Reset values: o_valid=0, o_data=0, o_frame_err=0, o_overflow=0. FIFOs empty, FSMs IDLE, synchronisers loaded with 1. A reset in the middle of a byte abandons it; no partial byte is pushed.
- Each channel has a 2-FF synchroniser on i_rx. The FSM acts on the synchronised value rx_s.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: rx_s==0 -> START, bit counter cleared, timer = DIV/2.
- START: timer expiry samples rx_s (mid start bit). Sample 1 -> IDLE (glitch rejected). Sample 0 -> DATA, timer = DIV.
- DATA: samples 8 bits, one every DIV cycles, LSB first, into a shift register. After bit 7 -> STOP.
- STOP: samples DIV cycles after bit 7.
  - Sample 1: push the byte, -> IDLE.
  - Sample 0: set o_frame_err, discard the byte, -> WAIT_IDLE.
- WAIT_IDLE: stays until rx_s==1, then -> IDLE.
- Timing: sample instants are t0+DIV/2+k*DIV, where t0 is the first cycle of IDLE with rx_s==0 and k=0 (start), 1..8 (data), 9 (stop). A pushed byte shows o_valid=1 on the cycle after the stop sample.
- FIFO behaviour:
  - First-word fall-through: o_data is the head entry whenever o_valid=1. o_data is undefined-but-stable (holds the last value) when o_valid=0.
  - Pop and push in the same cycle are both accepted. When full with a simultaneous pop, the push is accepted and the count is unchanged.
  - Push when full with no pop: byte dropped, o_overflow set, FIFO contents unchanged.
  - Pointers are log2(FIFO_DEPTH) bits plus 1 wrap bit. full = pointers equal except the MSB.
- Sticky flags clear on i_clr or rst. If i_clr and a new error land in the same cycle, the error wins (flag stays 1).
- Channels are fully independent; no arbitration.

Optional Feature:
SIM_UART_PRINT_EN
- Defined: each accepted push is also written to the simulator console via $write as the raw character. A "[uartN] " prefix is emitted at the start of each line (after 0x0A) when CHANNELS>1. Frame errors and overflows print a $display warning with the channel number and time.
- Undefined: no system tasks; the block is lint-clean for Verilator without any --public flags.
- RTL-visible behaviour is identical either way.

Decomposition:
- Package sim_uart_pkg: state enum typedef (IDLE, START, DATA, STOP, WAIT_IDLE), DIV_CALC constant function, byte typedef.
- Sub-module sim_uart_rx_chan: one channel (synchroniser, FSM, timer, FIFO, sticky flags). Instantiated CHANNELS times by a generate loop in sim_uart_rx_monitor. The top is only wiring and the i_clr fan-out.

Test Plan:
1. CLK_FREQ_HZ=1_000_000, BAUD=100_000 (DIV=10). Send 0x55 on ch0 with i_ready=1. Expect o_valid[0]=1 for exactly 1 cycle at t0+96, with o_data=0x55.
2. Drive i_rx low for 3 cycles, then high. Expect no push, FSM back in IDLE, o_frame_err=0.
3. Send 0xA3 with stop bit 0, held low 15 cycles. Expect no push and o_frame_err[0]=1. It remains set until the i_clr pulse and is 0 the cycle after.
4. FIFO_DEPTH=4, i_ready=0, send 0x01..0x05. Expect o_overflow[0]=1 after the 5th stop sample. Raising i_ready drains 0x01,0x02,0x03,0x04 on consecutive cycles, then o_valid=0.
5. CHANNELS=2, send 0x12 on ch0 and 0x34 on ch1 offset by 3 cycles. Expect independent valids 3 cycles apart, correct bytes, no cross-talk.
6. Assert rst for 1 cycle during bit 4 of 0x7E. After release: FIFO empty, no byte emitted for that frame. The next full 0x41 frame decodes correctly.

Source files
------------

// File: rtl/sim_uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sim_uart_pkg : shared types and constants for the UART receive monitor     |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
package sim_uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } rx_state_t;

  typedef logic [7:0] byte_t;

  // Clock cycles per bit, truncated.
  function automatic int DIV_CALC(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sim_uart_rx_chan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sim_uart_rx_chan : one monitored serial line (sync, framing FSM, FIFO)     |
// | Revision         : 1.0                                                     |
// +----------------------------------------------------------------------------+
module sim_uart_rx_chan
  import sim_uart_pkg::*;
#(
  parameter int DIV        = 108,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx,
  input  logic       i_clr,
  input  logic       i_ready,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_overflow
);

  localparam int              c_aw       = $clog2(FIFO_DEPTH);
  localparam int              c_tw       = $clog2(DIV + 1);
  localparam logic [c_tw-1:0] c_full_bit = c_tw'(DIV);
  localparam logic [c_tw-1:0] c_half_bit = c_tw'(DIV / 2);
  localparam logic [c_tw-1:0] c_tick     = c_tw'(1);

  logic            r_sync1;
  logic            r_rx_s;
  rx_state_t       r_state;
  logic [c_tw-1:0] r_timer;
  logic [2:0]      r_bit_cnt;
  byte_t           r_shift;
  logic [c_aw:0]   r_wr_ptr;
  logic [c_aw:0]   r_rd_ptr;
  byte_t           r_mem [FIFO_DEPTH];
  byte_t           r_last;
  logic            r_frame_err;
  logic            r_overflow;

  logic w_tick, w_stop_smp, w_push, w_ferr;
  logic w_empty, w_full, w_pop, w_push_ok, w_drop;

  // Timer reaching 1 marks the sampling cycle, so the reload value is the full spacing.
  assign w_tick     = (r_timer == c_tick);
  assign w_stop_smp = (r_state == STOP) && w_tick;
  assign w_push     = w_stop_smp && r_rx_s;
  assign w_ferr     = w_stop_smp && !r_rx_s;

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                     (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
  assign w_pop     = !w_empty && i_ready;
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_drop    = w_push && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= 1'b1;
      r_rx_s    <= 1'b1;
      r_state   <= IDLE;
      r_timer   <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      r_sync1 <= i_rx;
      r_rx_s  <= r_sync1;
      case (r_state)
        IDLE: begin
          if (!r_rx_s) begin
            r_state   <= START;
            r_bit_cnt <= '0;
            r_timer   <= c_half_bit;
          end
        end
        START: begin
          if (w_tick) begin
            if (r_rx_s) begin
              r_state <= IDLE;
            end else begin
              r_state <= DATA;
              r_timer <= c_full_bit;
            end
          end else begin
            r_timer <= r_timer - c_tick;
          end
        end
        DATA: begin
          if (w_tick) begin
            r_shift   <= {r_rx_s, r_shift[7:1]};
            r_timer   <= c_full_bit;
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_state <= STOP;
          end else begin
            r_timer <= r_timer - c_tick;
          end
        end
        STOP: begin
          if (w_tick) begin
            r_state <= r_rx_s ? IDLE : WAIT_IDLE;
          end else begin
            r_timer <= r_timer - c_tick;
          end
        end
        WAIT_IDLE: begin
          if (r_rx_s) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[c_aw-1:0]] <= r_shift;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_last      <= '0;
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_last   <= r_mem[r_rd_ptr[c_aw-1:0]];
      end
      // A new error in the same cycle as a clear keeps the flag set.
      if (w_ferr)     r_frame_err <= 1'b1;
      else if (i_clr) r_frame_err <= 1'b0;
      if (w_drop)     r_overflow  <= 1'b1;
      else if (i_clr) r_overflow  <= 1'b0;
    end
  end

  assign o_valid     = !w_empty;
  assign o_data      = w_empty ? r_last : r_mem[r_rd_ptr[c_aw-1:0]];
  assign o_frame_err = r_frame_err;
  assign o_overflow  = r_overflow;

endmodule
`default_nettype wire

// File: rtl/sim_uart_rx_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sim_uart_rx_monitor : multi-channel UART RX monitor; console echo with     |
// |                       SIM_UART_PRINT_EN.  Revision : 1.0                   |
// +----------------------------------------------------------------------------+
module sim_uart_rx_monitor
  import sim_uart_pkg::*;
#(
  parameter int CHANNELS    = 1,
  parameter int CLK_FREQ_HZ = 12_500_000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CHANNELS-1:0]   i_rx,
  input  logic                  i_clr,
  output logic [8*CHANNELS-1:0] o_data,
  output logic [CHANNELS-1:0]   o_valid,
  input  logic [CHANNELS-1:0]   i_ready,
  output logic [CHANNELS-1:0]   o_frame_err,
  output logic [CHANNELS-1:0]   o_overflow
);

  localparam int c_div = DIV_CALC(CLK_FREQ_HZ, BAUD);

  if (c_div < 4) begin : g_bad_div
    $error("sim_uart_rx_monitor: CLK_FREQ_HZ/BAUD must be at least 4");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sim_uart_rx_monitor: FIFO_DEPTH must be a power of two >= 2");
  end

  for (genvar n = 0; n < CHANNELS; n++) begin : g_chan
    sim_uart_rx_chan #(
      .DIV        (c_div),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .i_rx        (i_rx[n]),
      .i_clr       (i_clr),
      .i_ready     (i_ready[n]),
      .o_data      (o_data[8*n +: 8]),
      .o_valid     (o_valid[n]),
      .o_frame_err (o_frame_err[n]),
      .o_overflow  (o_overflow[n])
    );

`ifdef SIM_UART_PRINT_EN
    logic r_line_start;
    always_ff @(posedge clk) begin
      if (rst) begin
        r_line_start <= 1'b1;
      end else begin
        if (u_chan.w_push_ok) begin
          if ((CHANNELS > 1) && r_line_start) $write("[uart%0d] ", n);
          $write("%c", u_chan.r_shift);
          r_line_start <= (u_chan.r_shift == 8'h0A);
        end
        if (u_chan.w_ferr) $display("sim_uart warning: framing error on channel %0d at %0t", n, $time);
        if (u_chan.w_drop) $display("sim_uart warning: overflow on channel %0d at %0t", n, $time);
      end
    end
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_sim_uart_rx_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sim_uart_rx_monitor : directed bench, 2 channels, DIV=10, depth 4       |
// | Revision               : 1.0                                               |
// +----------------------------------------------------------------------------+
module tb_sim_uart_rx_monitor;

  localparam int DIV = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        rx0 = 1'b1, rx1 = 1'b1;
  logic        rdy0 = 1'b0, rdy1 = 1'b0;
  logic [15:0] dut_data;
  logic [1:0]  dut_valid, dut_ferr, dut_ovf;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int          pop_cyc0[$], pop_cyc1[$];
  logic [7:0]  pop_dat0[$], pop_dat1[$];

  sim_uart_rx_monitor #(
    .CHANNELS    (2),
    .CLK_FREQ_HZ (1_000_000),
    .BAUD        (100_000),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_rx        ({rx1, rx0}),
    .i_clr       (clr),
    .o_data      (dut_data),
    .o_valid     (dut_valid),
    .i_ready     ({rdy1, rdy0}),
    .o_frame_err (dut_ferr),
    .o_overflow  (dut_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Log every handshake; cyc is the posedge count just before the pop edge.
  always @(negedge clk) begin
    #1;
    if (dut_valid[0] && rdy0) begin
      pop_cyc0.push_back(cyc);
      pop_dat0.push_back(dut_data[7:0]);
    end
    if (dut_valid[1] && rdy1) begin
      pop_cyc1.push_back(cyc);
      pop_dat1.push_back(dut_data[15:8]);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input int ch, input logic v);
    if (ch == 0) rx0 = v;
    else         rx1 = v;
  endtask

  // Must be called on a negedge; returns on a negedge with the line idle.
  task automatic send_frame(input int ch, input logic [7:0] b, input logic stop_v, input int stop_cycles);
    drive(ch, 1'b0);
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      drive(ch, b[i]);
      repeat (DIV) @(negedge clk);
    end
    drive(ch, stop_v);
    repeat (stop_cycles) @(negedge clk);
    drive(ch, 1'b1);
  endtask

  task automatic clear_logs();
    pop_cyc0.delete(); pop_dat0.delete();
    pop_cyc1.delete(); pop_dat1.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (dut_valid !== 2'b00) begin failures++; $display("FAIL reset_valid: got %b expected 00", dut_valid); end
    checks++; if (dut_data !== 16'h0000) begin failures++; $display("FAIL reset_data: got %h expected 0000", dut_data); end
    checks++; if (dut_ferr !== 2'b00) begin failures++; $display("FAIL reset_frame_err: got %b expected 00", dut_ferr); end
    checks++; if (dut_ovf !== 2'b00) begin failures++; $display("FAIL reset_overflow: got %b expected 00", dut_ovf); end
  endtask

  task automatic test_basic();
    int t0;
    clear_logs();
    rdy0 = 1'b1;
    @(negedge clk);
    t0 = cyc;
    send_frame(0, 8'h55, 1'b1, DIV);
    repeat (DIV) @(negedge clk);
    checks++;
    if (pop_dat0.size() !== 1) begin
      failures++; $display("FAIL basic_count: got %0d pops expected 1", pop_dat0.size());
    end else begin
      checks++; if (pop_dat0[0] !== 8'h55) begin failures++; $display("FAIL basic_data: got %h expected 55", pop_dat0[0]); end
      checks++; if (pop_cyc0[0] !== t0 + 98) begin failures++; $display("FAIL basic_latency: got %0d expected %0d", pop_cyc0[0] - t0, 98); end
    end
    checks++; if (dut_valid[0] !== 1'b0) begin failures++; $display("FAIL basic_valid_after: got %b expected 0", dut_valid[0]); end
  endtask

  task automatic test_glitch();
    int t0;
    clear_logs();
    rdy0 = 1'b1;
    @(negedge clk);
    rx0 = 1'b0;
    repeat (3) @(negedge clk);
    rx0 = 1'b1;
    repeat (3 * DIV) @(negedge clk);
    checks++; if (pop_dat0.size() !== 0) begin failures++; $display("FAIL glitch_no_push: got %0d pops expected 0", pop_dat0.size()); end
    checks++; if (dut_ferr[0] !== 1'b0) begin failures++; $display("FAIL glitch_frame_err: got %b expected 0", dut_ferr[0]); end
    t0 = cyc;
    send_frame(0, 8'hC9, 1'b1, DIV);
    repeat (DIV) @(negedge clk);
    checks++;
    if (pop_dat0.size() !== 1) begin
      failures++; $display("FAIL glitch_followup_count: got %0d pops expected 1", pop_dat0.size());
    end else begin
      checks++; if (pop_dat0[0] !== 8'hC9) begin failures++; $display("FAIL glitch_followup_data: got %h expected c9", pop_dat0[0]); end
      checks++; if (pop_cyc0[0] !== t0 + 98) begin failures++; $display("FAIL glitch_followup_latency: got %0d expected 98", pop_cyc0[0] - t0); end
    end
  endtask

  task automatic test_frame_err();
    clear_logs();
    rdy0 = 1'b1;
    @(negedge clk);
    send_frame(0, 8'hA3, 1'b0, 15);
    repeat (2 * DIV) @(negedge clk);
    checks++; if (pop_dat0.size() !== 0) begin failures++; $display("FAIL ferr_no_push: got %0d pops expected 0", pop_dat0.size()); end
    checks++; if (dut_ferr[0] !== 1'b1) begin failures++; $display("FAIL ferr_set: got %b expected 1", dut_ferr[0]); end
    repeat (DIV) @(negedge clk);
    checks++; if (dut_ferr[0] !== 1'b1) begin failures++; $display("FAIL ferr_sticky: got %b expected 1", dut_ferr[0]); end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checks++; if (dut_ferr[0] !== 1'b0) begin failures++; $display("FAIL ferr_clear: got %b expected 0", dut_ferr[0]); end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_b;
    clear_logs();
    rdy0 = 1'b0;
    @(negedge clk);
    for (int k = 1; k <= 4; k++) send_frame(0, 8'(k), 1'b1, DIV);
    checks++; if (dut_ovf[0] !== 1'b0) begin failures++; $display("FAIL ovf_before: got %b expected 0", dut_ovf[0]); end
    checks++; if (dut_valid[0] !== 1'b1) begin failures++; $display("FAIL ovf_valid_held: got %b expected 1", dut_valid[0]); end
    checks++; if (dut_data[7:0] !== 8'h01) begin failures++; $display("FAIL ovf_head: got %h expected 01", dut_data[7:0]); end
    send_frame(0, 8'h05, 1'b1, DIV);
    repeat (2) @(negedge clk);
    checks++; if (dut_ovf[0] !== 1'b1) begin failures++; $display("FAIL ovf_set: got %b expected 1", dut_ovf[0]); end
    rdy0 = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (pop_dat0.size() !== 4) begin
      failures++; $display("FAIL ovf_drain_count: got %0d pops expected 4", pop_dat0.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        exp_b = 8'(k + 1);
        checks++; if (pop_dat0[k] !== exp_b) begin failures++; $display("FAIL ovf_drain_data%0d: got %h expected %h", k, pop_dat0[k], exp_b); end
        checks++; if (pop_cyc0[k] !== pop_cyc0[0] + k) begin failures++; $display("FAIL ovf_drain_cycle%0d: got +%0d expected +%0d", k, pop_cyc0[k] - pop_cyc0[0], k); end
      end
    end
    checks++; if (dut_valid[0] !== 1'b0) begin failures++; $display("FAIL ovf_empty_after: got %b expected 0", dut_valid[0]); end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checks++; if (dut_ovf[0] !== 1'b0) begin failures++; $display("FAIL ovf_clear: got %b expected 0", dut_ovf[0]); end
  endtask

  task automatic test_two_channels();
    int t0;
    clear_logs();
    rdy0 = 1'b1;
    rdy1 = 1'b1;
    @(negedge clk);
    t0 = cyc;
    fork
      send_frame(0, 8'h12, 1'b1, DIV);
      begin
        repeat (3) @(negedge clk);
        send_frame(1, 8'h34, 1'b1, DIV);
      end
    join
    repeat (DIV) @(negedge clk);
    checks++;
    if (pop_dat0.size() !== 1) begin
      failures++; $display("FAIL dual_ch0_count: got %0d pops expected 1", pop_dat0.size());
    end else begin
      checks++; if (pop_dat0[0] !== 8'h12) begin failures++; $display("FAIL dual_ch0_data: got %h expected 12", pop_dat0[0]); end
      checks++; if (pop_cyc0[0] !== t0 + 98) begin failures++; $display("FAIL dual_ch0_latency: got %0d expected 98", pop_cyc0[0] - t0); end
    end
    checks++;
    if (pop_dat1.size() !== 1) begin
      failures++; $display("FAIL dual_ch1_count: got %0d pops expected 1", pop_dat1.size());
    end else begin
      checks++; if (pop_dat1[0] !== 8'h34) begin failures++; $display("FAIL dual_ch1_data: got %h expected 34", pop_dat1[0]); end
      checks++; if (pop_cyc1[0] !== t0 + 101) begin failures++; $display("FAIL dual_ch1_latency: got %0d expected 101", pop_cyc1[0] - t0); end
    end
    checks++; if (dut_ferr !== 2'b00) begin failures++; $display("FAIL dual_frame_err: got %b expected 00", dut_ferr); end
  endtask

  task automatic test_reset_mid_frame();
    int t0;
    logic [7:0] b;
    clear_logs();
    rdy0 = 1'b1;
    b = 8'h7E;
    @(negedge clk);
    rx0 = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx0 = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx0 = b[4];
    repeat (DIV / 2) @(negedge clk);
    rst = 1'b1;
    rx0 = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3 * DIV) @(negedge clk);
    checks++; if (pop_dat0.size() !== 0) begin failures++; $display("FAIL rstmid_no_push: got %0d pops expected 0", pop_dat0.size()); end
    checks++; if (dut_valid[0] !== 1'b0) begin failures++; $display("FAIL rstmid_valid: got %b expected 0", dut_valid[0]); end
    t0 = cyc;
    send_frame(0, 8'h41, 1'b1, DIV);
    repeat (DIV) @(negedge clk);
    checks++;
    if (pop_dat0.size() !== 1) begin
      failures++; $display("FAIL rstmid_next_count: got %0d pops expected 1", pop_dat0.size());
    end else begin
      checks++; if (pop_dat0[0] !== 8'h41) begin failures++; $display("FAIL rstmid_next_data: got %h expected 41", pop_dat0[0]); end
      checks++; if (pop_cyc0[0] !== t0 + 98) begin failures++; $display("FAIL rstmid_next_latency: got %0d expected 98", pop_cyc0[0] - t0); end
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    test_basic();
    test_glitch();
    test_frame_err();
    test_overflow();
    test_two_channels();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
